// File: rtl/ahb_gpio_pinmux.sv
// ---------------------------------------------------------------------------
// ahb_gpio_pinmux
// AHB-Lite slave GPIO controller with per-pin alternate-function muxing,
// input synchronisers and per-pin edge/level interrupts.
//
// Ports:
//   HCLK, HRESET            clock, asynchronous active-high reset
//   HSEL..HREADY            AHB-Lite slave inputs (zero wait state slave)
//   HREADYOUT, HRDATA, HRESP AHB-Lite slave outputs
//   PAD_IN                  raw (asynchronous) pad inputs
//   PAD_OUT, PAD_EN         pad output value / output enable after the mux
//   ALT_OUT, ALT_EN         alternate-function drivers, index pin*NUM_ALT+(f-1)
//   PIN_SYNC                synchronised pad inputs
//   PIN_IRQ, IRQ            registered per-pin interrupts and their OR
//
// Register map (byte offsets): 0x000 DATA, 0x004 DOUT, 0x008 OEN,
// 0x010 DOUTSET, 0x014 DOUTCLR, 0x020 INTEN, 0x024 INTTYPE, 0x028 INTPOL,
// 0x02C INTSTAT, 0x040+4k ALTSEL_k (4-bit select per pin, 8 pins per word).
// ---------------------------------------------------------------------------
module ahb_gpio_pinmux #(
   parameter int NUM_PINS    = 16,
   parameter int NUM_ALT     = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        HCLK,
   input  logic                        HRESET,
   input  logic                        HSEL,
   input  logic [11:0]                 HADDR,
   input  logic [1:0]                  HTRANS,
   input  logic [2:0]                  HSIZE,
   input  logic                        HWRITE,
   input  logic [31:0]                 HWDATA,
   input  logic                        HREADY,
   output logic                        HREADYOUT,
   output logic [31:0]                 HRDATA,
   output logic                        HRESP,
   input  logic [NUM_PINS-1:0]         PAD_IN,
   output logic [NUM_PINS-1:0]         PAD_OUT,
   output logic [NUM_PINS-1:0]         PAD_EN,
   input  logic [NUM_PINS*NUM_ALT-1:0] ALT_OUT,
   input  logic [NUM_PINS*NUM_ALT-1:0] ALT_EN,
   output logic [NUM_PINS-1:0]         PIN_SYNC,
   output logic [NUM_PINS-1:0]         PIN_IRQ,
   output logic                        IRQ
);

   // Word indices (byte offset / 4)
   localparam logic [9:0] W_DATA    = 10'h000;
   localparam logic [9:0] W_DOUT    = 10'h001;
   localparam logic [9:0] W_OEN     = 10'h002;
   localparam logic [9:0] W_DOUTSET = 10'h004;
   localparam logic [9:0] W_DOUTCLR = 10'h005;
   localparam logic [9:0] W_INTEN   = 10'h008;
   localparam logic [9:0] W_INTTYPE = 10'h009;
   localparam logic [9:0] W_INTPOL  = 10'h00A;
   localparam logic [9:0] W_INTSTAT = 10'h00B;

   // ---------------- bus address phase ----------------
   logic        accept;
   logic        wr_q, rd_q, size_ok_q;
   logic [11:0] addr_q;
   logic [9:0]  sel_word;
   logic        wr_ok;
   logic        unused_ok;

   assign accept    = HSEL & HREADY & HTRANS[1];
   assign unused_ok = &{1'b0, HTRANS[0]};

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         size_ok_q <= 1'b0;
         addr_q    <= '0;
      end else if (HREADY) begin
         wr_q      <= accept & HWRITE;
         rd_q      <= accept & ~HWRITE;
         size_ok_q <= (HSIZE == 3'b010);
         addr_q    <= HADDR;
      end
   end

   // Unaligned addresses map to an unused word so they decode as unmapped.
   assign sel_word = (addr_q[1:0] == 2'b00) ? addr_q[11:2] : 10'h3FF;
   assign wr_ok    = wr_q & size_ok_q;

   // ---------------- input synchroniser (shift chain) ----------------
   logic [SYNC_STAGES*NUM_PINS-1:0] sync_q;
   logic [NUM_PINS-1:0]             pin_sync;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) sync_q <= '0;
      else        sync_q <= {sync_q[(SYNC_STAGES-1)*NUM_PINS-1:0], PAD_IN};
   end

   assign pin_sync = sync_q[SYNC_STAGES*NUM_PINS-1 -: NUM_PINS];
   assign PIN_SYNC = pin_sync;

   // ---------------- GPIO / interrupt registers ----------------
   logic [NUM_PINS-1:0] dout_q, dout_d, oen_q, oen_d;
   logic [NUM_PINS-1:0] inten_q, inten_d, inttype_q, inttype_d, intpol_q, intpol_d;
   logic [NUM_PINS-1:0] edge_q, edge_d, prev_q, pin_irq_q, status;
   logic [NUM_PINS-1:0] wdat, w1c, rise, fall, edge_set;
   logic [4*NUM_PINS-1:0] altsel_q, altsel_d;

   assign wdat = HWDATA[NUM_PINS-1:0];

   always_comb begin
      dout_d    = dout_q;
      oen_d     = oen_q;
      inten_d   = inten_q;
      inttype_d = inttype_q;
      intpol_d  = intpol_q;
      if (wr_ok) begin
         case (sel_word)
            W_DOUT:    dout_d    = wdat;
            W_OEN:     oen_d     = wdat;
            W_DOUTSET: dout_d    = dout_q | wdat;
            W_DOUTCLR: dout_d    = dout_q & ~wdat;
            W_INTEN:   inten_d   = wdat;
            W_INTTYPE: inttype_d = wdat;
            W_INTPOL:  intpol_d  = wdat;
            default:   ;
         endcase
      end
   end

   assign rise     = pin_sync & ~prev_q;
   assign fall     = ~pin_sync & prev_q;
   assign w1c      = (wr_ok && sel_word == W_INTSTAT) ? wdat : '0;
   assign edge_set = inten_q & inttype_q & ((intpol_q & rise) | (~intpol_q & fall));
   // Set is OR-ed in after the clear so a coincident edge wins; the final mask
   // drops latched edges on disabled pins and on pins switched to level mode.
   assign edge_d   = ((edge_q & ~w1c) | edge_set) & inten_q & inttype_q;
   assign status   = inten_q & ((inttype_q & edge_q) |
                                (~inttype_q & ~(pin_sync ^ intpol_q)));

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         dout_q    <= '0;
         oen_q     <= '0;
         inten_q   <= '0;
         inttype_q <= '0;
         intpol_q  <= '0;
         edge_q    <= '0;
         prev_q    <= '0;
         pin_irq_q <= '0;
         altsel_q  <= '0;
      end else begin
         dout_q    <= dout_d;
         oen_q     <= oen_d;
         inten_q   <= inten_d;
         inttype_q <= inttype_d;
         intpol_q  <= intpol_d;
         edge_q    <= edge_d;
         prev_q    <= pin_sync;
         pin_irq_q <= status;
         altsel_q  <= altsel_d;
      end
   end

   assign PIN_IRQ = pin_irq_q;
   assign IRQ     = |pin_irq_q;

   // ---------------- ALTSEL registers and pad mux ----------------
   logic [NUM_PINS*NUM_ALT-1:0] alt_hit;
   logic [127:0]                asel_all;   // select fields of all 32 possible pins
   logic [31:0]                 asel_rd;

   for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
      logic alt_sel;

      assign altsel_d[4*gi +: 4] = (wr_ok && sel_word == 10'(16 + gi / 8)) ?
                                   HWDATA[4*(gi % 8) +: 4] : altsel_q[4*gi +: 4];

      for (genvar fi = 0; fi < NUM_ALT; fi++) begin : g_fn
         assign alt_hit[gi*NUM_ALT + fi] = (altsel_q[4*gi +: 4] == 4'(fi + 1));
      end

      // No hit means select 0 or out of range: the pin stays GPIO.
      assign alt_sel     = |alt_hit[gi*NUM_ALT +: NUM_ALT];
      assign PAD_OUT[gi] = alt_sel ? |(alt_hit[gi*NUM_ALT +: NUM_ALT] & ALT_OUT[gi*NUM_ALT +: NUM_ALT])
                                   : dout_q[gi];
      assign PAD_EN[gi]  = alt_sel ? |(alt_hit[gi*NUM_ALT +: NUM_ALT] & ALT_EN[gi*NUM_ALT +: NUM_ALT])
                                   : oen_q[gi];
   end

   for (genvar gi = 0; gi < 32; gi++) begin : g_asel_rd
      if (gi < NUM_PINS) begin : g_real
         assign asel_all[4*gi +: 4] = altsel_q[4*gi +: 4];
      end else begin : g_absent
         assign asel_all[4*gi +: 4] = 4'h0;
      end
   end

   assign asel_rd = asel_all[{sel_word[1:0], 5'b00000} +: 32];

   // ---------------- read data ----------------
   logic [31:0] rdata;

   always_comb begin
      rdata = '0;
      case (sel_word)
         W_DATA:    rdata = 32'(pin_sync);
         W_DOUT:    rdata = 32'(dout_q);
         W_OEN:     rdata = 32'(oen_q);
         W_INTEN:   rdata = 32'(inten_q);
         W_INTTYPE: rdata = 32'(inttype_q);
         W_INTPOL:  rdata = 32'(intpol_q);
         W_INTSTAT: rdata = 32'(status);
         default:   if (sel_word[9:2] == 8'h04) rdata = asel_rd;
      endcase
   end

   assign HRDATA    = rd_q ? rdata : 32'h0;
   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;

endmodule
